// File: rtl/psum_row_fifo.sv
// Synchronous FIFO for aligned psum rows.
// Ports: push/wdata in, pop/rdata out, full/empty/count status.
module psum_row_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same edge frees the slot, so a full push is legal then.
  assign do_push = push & (~full | do_pop);
  // Head is registered storage; zeroed while empty.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Deskews staggered PE-array column psums into aligned rows, buffers them,
// and hands them off on valid/ready; raises array_hold ahead of overflow.
// Ports: psum_in/psum_valid_in from array, row_out/row_valid/row_ready out,
// array_hold to controller, sticky overflow, rows_out handoff counter.
module psum_drain #(
  parameter int PSUM_WIDTH = 16,
  parameter int NUM_COLS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_COLS*PSUM_WIDTH-1:0] psum_in,
  input  logic                           psum_valid_in,
  output logic                           array_hold,
  output logic [NUM_COLS*PSUM_WIDTH-1:0] row_out,
  output logic                           row_valid,
  input  logic                           row_ready,
  output logic                           overflow,
  output logic [15:0]                    rows_out
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int LAST = NUM_COLS - 1;
  localparam int RW   = NUM_COLS * PSUM_WIDTH;

  logic [RW-1:0] aligned;
  logic          push;
  logic [CW:0]   inflight;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          pop;
  logic [CW:0]   need;
  logic [CW:0]   free;

  genvar c;
  generate
    for (c = 0; c < NUM_COLS; c++) begin : g_col
      if (c == LAST) begin : g_pass
        assign aligned[c*PSUM_WIDTH +: PSUM_WIDTH] =
          psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
      end else begin : g_dly
        localparam int D = LAST - c;
        logic [PSUM_WIDTH-1:0] sr [D];
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
          end else begin
            sr[0] <= psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
          end
        end
        assign aligned[c*PSUM_WIDTH +: PSUM_WIDTH] = sr[D-1];
      end
    end

    if (NUM_COLS == 1) begin : g_v0
      assign push     = psum_valid_in;
      assign inflight = '0;
    end else begin : g_vn
      logic [LAST-1:0] vsr;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vsr <= '0;
        end else begin
          vsr[0] <= psum_valid_in;
          for (int i = 1; i < LAST; i++) vsr[i] <= vsr[i-1];
        end
      end
      assign push = vsr[LAST-1];
      always_comb begin
        inflight = '0;
        for (int i = 0; i < LAST; i++)
          inflight = inflight + (CW+1)'(vsr[i]);
      end
    end
  endgenerate

  assign row_valid = ~empty;
  assign pop       = row_ready;

  psum_row_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (aligned),
    .pop   (pop),
    .rdata (row_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Every row already in the deskew chain, plus the LAST rows the array
  // may still emit, must fit in the free slots.
  assign need       = (CW+1)'(LAST) + inflight;
  assign free       = (CW+1)'(FIFO_DEPTH) - {1'b0, count};
  assign array_hold = (free <= need);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      rows_out <= '0;
    end else begin
      if (push & full & ~row_ready) overflow <= 1'b1;
      if (row_valid & row_ready)    rows_out <= rows_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed testbench for psum_drain (NUM_COLS=4, FIFO_DEPTH=8).
// Drives staggered column data and checks alignment, hold, overflow, wrap.
module tb_psum_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] psum_in;
  logic        psum_valid_in;
  logic        array_hold;
  logic [63:0] row_out;
  logic        row_valid;
  logic        row_ready;
  logic        overflow;
  logic [15:0] rows_out;

  int checks = 0;
  int errors = 0;

  bit          hv [4];
  logic [15:0] hb [4];

  always #5 clk = ~clk;

  psum_drain #(
    .PSUM_WIDTH (16),
    .NUM_COLS   (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .psum_in       (psum_in),
    .psum_valid_in (psum_valid_in),
    .array_hold    (array_hold),
    .row_out       (row_out),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .overflow      (overflow),
    .rows_out      (rows_out)
  );

  function automatic logic [63:0] rowv(input logic [15:0] b);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Column c shows the row issued c cycles ago (value base+c).
  task automatic tick(input bit v, input logic [15:0] b);
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      hb[i] = hb[i-1];
    end
    hv[0] = v;
    hb[0] = b;
    psum_valid_in = v;
    for (int c = 0; c < 4; c++)
      psum_in[c*16 +: 16] = hv[c] ? hb[c] + 16'(c) : 16'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hb[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_hist();
    tick(1'b1, 16'h7000);
    tick(1'b0, 16'h0);
    rst_n = 1'b1;
    clear_hist();
  endtask

  task automatic test_reset();
    row_ready = 1'b0;
    do_reset();
    checks++;
    if (row_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", row_valid);
    end
    checks++;
    if (row_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_row got %h want 0", row_out);
    end
    checks++;
    if (array_hold !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got hold=%b ovf=%b want 0 0",
               array_hold, overflow);
    end
    checks++;
    if (rows_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_rows got %h want 0", rows_out);
    end
  endtask

  task automatic test_single_row();
    row_ready = 1'b1;
    tick(1'b1, 16'h0100);
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (row_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early k=%0d got %b want 0", k, row_valid);
      end
      tick(1'b0, 16'h0);
    end
    checks++;
    if (row_valid !== 1'b1 || row_out !== 64'h0103_0102_0101_0100) begin
      errors++;
      $display("FAIL single_row got v=%b %h want 1 %h", row_valid,
               row_out, 64'h0103_0102_0101_0100);
    end
    tick(1'b0, 16'h0);
    checks++;
    if (row_valid !== 1'b0 || rows_out !== 16'd1) begin
      errors++;
      $display("FAIL single_after got v=%b rows=%0d want 0 1",
               row_valid, rows_out);
    end
  endtask

  task automatic test_hold();
    int k_hold;
    int n;
    do_reset();
    row_ready = 1'b0;
    k_hold = -1;
    n = 0;
    // Controller model: sees hold in cycle k, still issues k, stops after.
    for (int k = 0; k < 20 && k_hold < 0; k++) begin
      if (array_hold) k_hold = k;
      tick(1'b1, 16'h2000 + 16'(n * 16));
      n++;
    end
    checks++;
    if (k_hold !== 5) begin
      errors++;
      $display("FAIL hold_rise got k=%0d want 5", k_hold);
    end
    for (int k = 0; k < 4; k++) tick(1'b0, 16'h0);
    checks++;
    if (overflow !== 1'b0 || array_hold !== 1'b1) begin
      errors++;
      $display("FAIL hold_state got ovf=%b hold=%b want 0 1",
               overflow, array_hold);
    end
    row_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      checks++;
      if (row_valid !== 1'b1 ||
          row_out !== rowv(16'h2000 + 16'(r * 16))) begin
        errors++;
        $display("FAIL hold_drain r=%0d got v=%b %h want %h", r,
                 row_valid, row_out, rowv(16'h2000 + 16'(r * 16)));
      end
      tick(1'b0, 16'h0);
    end
    checks++;
    if (row_valid !== 1'b0 || rows_out !== 16'd6 ||
        array_hold !== 1'b0) begin
      errors++;
      $display("FAIL hold_end got v=%b rows=%0d hold=%b want 0 6 0",
               row_valid, rows_out, array_hold);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    row_ready = 1'b0;
    for (int r = 0; r < 8; r++) tick(1'b1, 16'h3000 + 16'(r * 16));
    for (int k = 0; k < 4; k++) tick(1'b0, 16'h0);
    tick(1'b1, 16'h3080);
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    checks++;
    if (row_valid !== 1'b1 || row_out !== rowv(16'h3000)) begin
      errors++;
      $display("FAIL fpp_head got v=%b %h want %h", row_valid, row_out,
               rowv(16'h3000));
    end
    row_ready = 1'b1;
    tick(1'b0, 16'h0);
    row_ready = 1'b0;
    tick(1'b0, 16'h0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fpp_ovf got %b want 0", overflow);
    end
    row_ready = 1'b1;
    for (int r = 1; r < 9; r++) begin
      checks++;
      if (row_valid !== 1'b1 ||
          row_out !== rowv(16'h3000 + 16'(r * 16))) begin
        errors++;
        $display("FAIL fpp_drain r=%0d got v=%b %h want %h", r,
                 row_valid, row_out, rowv(16'h3000 + 16'(r * 16)));
      end
      tick(1'b0, 16'h0);
    end
    checks++;
    if (row_valid !== 1'b0 || rows_out !== 16'd9) begin
      errors++;
      $display("FAIL fpp_end got v=%b rows=%0d want 0 9",
               row_valid, rows_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    row_ready = 1'b0;
    // Row r pushes at the end of cycle r+3; the 9th (r=8) at cycle 11.
    for (int k = 0; k < 14; k++) begin
      if (k == 11) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got %b want 0", overflow);
        end
      end
      if (k == 12) begin
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set got %b want 1", overflow);
        end
      end
      tick(k < 10, 16'h4000 + 16'(k * 16));
    end
    row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (row_valid !== 1'b1 ||
          row_out !== rowv(16'h4000 + 16'(r * 16))) begin
        errors++;
        $display("FAIL ovf_drain r=%0d got v=%b %h want %h", r,
                 row_valid, row_out, rowv(16'h4000 + 16'(r * 16)));
      end
      tick(1'b0, 16'h0);
    end
    checks++;
    if (row_valid !== 1'b0 || rows_out !== 16'd8 ||
        overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end got v=%b rows=%0d ovf=%b want 0 8 1",
               row_valid, rows_out, overflow);
    end
  endtask

  // Entered with overflow=1 and rows_out=8 from the previous test.
  task automatic test_reset_midflight();
    row_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick(1'b1, 16'h5000 + 16'(k * 16));
    tick(1'b0, 16'h0);
    checks++;
    if (row_valid !== 1'b1 || row_out !== rowv(16'h5000)) begin
      errors++;
      $display("FAIL mid_pre got v=%b %h want %h", row_valid, row_out,
               rowv(16'h5000));
    end
    rst_n = 1'b0;
    tick(1'b1, 16'h6000);
    checks++;
    if (row_valid !== 1'b0 || rows_out !== 16'd0 ||
        overflow !== 1'b0 || array_hold !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b rows=%0d ovf=%b hold=%b",
               row_valid, rows_out, overflow, array_hold);
    end
    rst_n = 1'b1;
    clear_hist();
    row_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (row_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost k=%0d got %b want 0", k, row_valid);
      end
      tick(1'b0, 16'h0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    row_ready = 1'b1;
    for (int r = 0; r < 65535; r++) tick(1'b1, 16'(r));
    for (int k = 0; k < 6; k++) tick(1'b0, 16'h0);
    checks++;
    if (rows_out !== 16'hFFFF || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pre got rows=%h ovf=%b want ffff 0",
               rows_out, overflow);
    end
    tick(1'b1, 16'h0AA0);
    for (int k = 0; k < 6; k++) tick(1'b0, 16'h0);
    checks++;
    if (rows_out !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got rows=%h want 0", rows_out);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    psum_in       = '0;
    psum_valid_in = 1'b0;
    row_ready     = 1'b0;
    clear_hist();
    test_reset();
    test_single_row();
    test_hold();
    test_full_push_pop();
    test_overflow();
    test_reset_midflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
